// File: rtl/k2red_pkg.sv
// Shared constants and FSM state type for the k^-2 removal (inverse shift) block.
// Optional build macro used by the block: K2RED_INV_PREREDUCE_EN.
package k2red_pkg;

    localparam int W_DEF = 32;
    localparam int EXP_W = 6;
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/k2red_inv_shift_if.sv
// Request/result bundle for k2red_inv_shift: the master issues start with operands,
// the slave reports busy, the one-cycle done pulse and the result.
interface k2red_inv_shift_if
    import k2red_pkg::*;
#(
    parameter int W = W_DEF
);
    logic             start;
    logic [W-1:0]     C;
    logic [W-1:0]     Q;
    logic [EXP_W-1:0] m;
    logic             busy;
    logic             done;
    logic [W-1:0]     R;

    modport master (output start, C, Q, m, input busy, done, R);
    modport slave  (input start, C, Q, m, output busy, done, R);
endinterface

// File: rtl/k2red_moddbl.sv
// Combinational conditional reduction: y = v mod q where v is 2x (dbl=1) or x (dbl=0),
// valid while v < 2q. The compare is done at W+1 bits so 2x never overflows.
module k2red_moddbl #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] q,
    input  logic         dbl,
    output logic [W-1:0] y
);
    logic [W:0] v_s;

    // Select doubled or plain operand, then subtract q once if it does not fit below q.
    always_comb begin
        v_s = {1'b0, x};
        y   = x;
        if (dbl) begin
            v_s = {x, 1'b0};
        end else begin
            v_s = {1'b0, x};
        end
        if (v_s >= {1'b0, q}) begin
            y = v_s[W-1:0] - q;
        end else begin
            y = v_s[W-1:0];
        end
    end
endmodule

// File: rtl/k2red_inv_shift.sv
// Removes the k^2 factor left by K2-RED: R = C * 2^(2m) mod Q by 2m modular doublings.
// Define K2RED_INV_PREREDUCE_EN to accept lazily reduced inputs C < 2Q.
module k2red_inv_shift
    import k2red_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    k2red_inv_shift_if.slave        bus
);
    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [W-1:0]       x_r;
    logic [W-1:0]       q_r;
    logic [W-1:0]       r_r;
    logic               busy_r;
    logic               done_r;
    logic [W-1:0]       dbl_s;
    logic [W-1:0]       cin_s;

    k2red_moddbl #(.W(W)) u_dbl (
        .x   (x_r),
        .q   (q_r),
        .dbl (1'b1),
        .y   (dbl_s)
    );

`ifdef K2RED_INV_PREREDUCE_EN
    k2red_moddbl #(.W(W)) u_pre (
        .x   (bus.C),
        .q   (bus.Q),
        .dbl (1'b0),
        .y   (cin_s)
    );
`else
    assign cin_s = bus.C;
`endif

    // Control FSM with datapath: capture in IDLE, double per RUN cycle, publish R on DONE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            x_r     <= {W{1'b0}};
            q_r     <= {W{1'b0}};
            r_r     <= {W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        x_r     <= cin_s;
                        q_r     <= bus.Q;
                        cnt_r   <= {bus.m, 1'b0};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        r_r     <= x_r;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        x_r     <= dbl_s;
                        cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    // start seen here is deliberately dropped; IDLE accepts the next one.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.R    = r_r;
endmodule

// File: tb/tb_k2red_inv_shift.sv
// Directed bench for k2red_inv_shift with hand-computed vectors for q = 16394*2^17 + 1.
// Build with K2RED_INV_PREREDUCE_EN to include the lazy-input case.
module tb_k2red_inv_shift;
    localparam logic [31:0] QV   = 32'd2148794369;
    localparam logic [5:0]  MV   = 6'd17;
    localparam logic [31:0] P34  = 32'd2138308601;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    k2red_inv_shift_if #(.W(32)) bus ();

    k2red_inv_shift #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: issues one start cycle, returns done latency (-1 on timeout) and busy in cycle 1.
    task automatic run_op(input logic [31:0] c, input logic [31:0] q, input logic [5:0] mm,
                          output int lat, output logic busy1);
        bus.C = c; bus.Q = q; bus.m = mm; bus.start = 1'b1;
        lat = -1;
        busy1 = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (i == 1) busy1 = bus.busy;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic op_check(input string tag, input logic [31:0] c, input logic [31:0] q,
                            input logic [5:0] mm, input logic [31:0] exp_r);
        int   lat;
        logic b1;
        run_op(c, q, mm, lat, b1);
        check({tag, "_busy"}, {63'd0, b1}, 64'd1);
        check({tag, "_lat"}, lat, 2 * mm + 2);
        check({tag, "_r"}, bus.R, exp_r);
        @(negedge clk);
        check({tag, "_done1cyc"}, {63'd0, bus.done}, 64'd0);
        check({tag, "_rhold"}, bus.R, exp_r);
    endtask

    initial begin
        int dones;
        logic [31:0] r_at_done;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.C = 32'd0; bus.Q = 32'd0; bus.m = 6'd0;
        #12;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_r", bus.R, 64'd0);

        // Release reset and issue start in the same cycle.
        @(negedge clk);
        rst = 1'b0;
        op_check("k2", 32'd268763236, QV, MV, 32'd1);
        op_check("one", 32'd1, QV, MV, P34);
        op_check("zero", 32'd0, QV, MV, 32'd0);
        op_check("qm1", 32'd2148794368, QV, MV, 32'd10485768);
        op_check("m0", 32'd12345, QV, 6'd0, 32'd12345);

        // Reset mid-RUN: operation is discarded, no done pulse afterwards.
        op_check("pre", 32'd1, QV, MV, P34);
        bus.C = 32'd1; bus.Q = QV; bus.m = MV; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("mid_rst_done", {63'd0, bus.done}, 64'd0);
        check("mid_rst_r", bus.R, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("mid_rst_nodone", dones, 64'd0);
        op_check("reissue", 32'd1, QV, MV, P34);

        // A second start during RUN must not restart or add a done.
        bus.C = 32'd268763236; bus.Q = QV; bus.m = MV; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.C = 32'd0; bus.m = 6'd0; bus.start = 1'b1;
        dones = 0;
        r_at_done = 32'd0;
        repeat (80) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                r_at_done = bus.R;
            end
        end
        check("ign_start_dones", dones, 64'd1);
        check("ign_start_r", r_at_done, 64'd1);

`ifdef K2RED_INV_PREREDUCE_EN
        op_check("pre_red", QV + 32'd1, QV, MV, P34);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/k2red_inv_shift.md
K2RED_INV_SHIFT -- requirements
Module: k2red_inv_shift

Interface
REQ-001 SHALL have parameter W, default 32: operand/modulus width in bits.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: request pulse, sampled only in IDLE.
REQ-005 SHALL have port C, input, W: value carrying k^2 factor (K2-RED output), C < Q.
REQ-006 SHALL have port Q, input, W: Proth prime q = k*2^m + 1, Q odd, Q < 2^W.
REQ-007 SHALL have port m, input, 6: power-of-two exponent of q.
REQ-008 SHALL have port busy, output, 1: high while in RUN.
REQ-009 SHALL have port done, output, 1: one-cycle pulse, result valid.
REQ-010 SHALL have port R, output, W: result C*k^-2 mod q.

Function
REQ-011 SHALL compute R = C*2^(2m) mod Q, using k^-1 ≡ -2^m (mod q), hence k^-2 ≡ 2^(2m).
REQ-012 SHALL use a 3-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE with start=1, capture C, Q and m into internal registers, load counter with 2*m (7 bits), and enter RUN.
REQ-014 SHALL, in RUN, per cycle: x <= (2x >= Q) ? 2x - Q : 2x, computed at W+1 bits; counter decrements.
REQ-015 SHALL leave RUN for DONE on the cycle its counter reaches 0.
REQ-016 SHALL, for m=0, pass from IDLE through RUN (zero doublings) to DONE, giving R = C.
REQ-017 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-018 SHALL have latency from start edge to done high of 2m+2 cycles.
REQ-019 SHALL update R only on entry to DONE and hold it until the next DONE.
REQ-020 SHALL ignore start outside IDLE, and SHALL ignore changes to C/Q/m after capture.
REQ-021 SHALL treat start asserted in the DONE cycle as ignored; start is accepted on the following IDLE cycle.
REQ-022 SHALL hold busy=1 exactly in RUN.

Reset
REQ-023 SHALL drive state=IDLE, busy=0, done=0, R=0, counter=0, x=0 on rst assertion, asynchronously, including mid-RUN; the in-flight operation is discarded with no done pulse.
REQ-024 SHALL be able to accept start on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL support macro K2RED_INV_PREREDUCE_EN: when defined, the captured input is C-Q if C >= Q, else C, which widens the legal input range to C < 2Q (raw lazy-reduced K2-RED output).
REQ-026 SHALL, without K2RED_INV_PREREDUCE_EN, capture C as-is; C >= Q is illegal and the result is unspecified.

Structure
REQ-027 SHALL place in package k2red_pkg: default W, exponent width 6, counter width 7, and the FSM state typedef.
REQ-028 SHALL use one combinational sub-module, k2red_moddbl, computing (2x mod Q) for x < Q, also used for the optional pre-reduce compare/subtract pattern.

Verification (Q=2148794369, m=17, k=16394)
REQ-029 SHALL cover: C=268763236 (k^2 mod q) -> R=1, done at cycle 36 after start.
REQ-030 SHALL cover: C=1 -> R=2138308601 (2^34 mod q); C=0 -> R=0.
REQ-031 SHALL cover: C=2148794368 (q-1) -> R=10485768.
REQ-032 SHALL cover: m=0, C=12345 -> R=12345, done 2 cycles after start.
REQ-033 SHALL cover: rst pulsed 10 cycles into RUN -> busy=0, R=0, no done; start re-issued -> correct result; start pulsed during RUN -> ignored, single done.
REQ-034 SHALL cover, with K2RED_INV_PREREDUCE_EN: C=q+1 -> R=2138308601.
